// File: rtl/controlador_contador.sv
`default_nettype none
// ============================================================================
// Module   : controlador_contador
// Purpose  : Round-robin two-client job sequencer driving a cascaded counter.
// Revision : 1.0
// ============================================================================
module controlador_contador #(
  parameter int W  = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [1:0]    req0_modo,
  input  logic [W-1:0]  req0_D,
  input  logic [LW-1:0] req0_len,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [1:0]    req1_modo,
  input  logic [W-1:0]  req1_D,
  input  logic [LW-1:0] req1_len,
  output logic          enb,
  output logic [1:0]    modo,
  output logic [W-1:0]  D,
  input  logic [W-1:0]  Q,
  input  logic [3:0]    RCO,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic [W-1:0]  done_Q,
  output logic          done_wrap
);

  localparam logic [1:0] MODO_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic [1:0]    jmodo_q, jmodo_d;
  logic [W-1:0]  jd_q, jd_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          wrap_q, wrap_d;
  logic          hold_id_q;
  logic          hold_wrap_q;
  logic [W-1:0]  hold_Q_q;

  logic          w_grant0;
  logic          w_grant1;
  logic          w_unused_rco;

  assign w_unused_rco = ^RCO[2:0];

  // Ready is gated by reset_L so no client sees an accept while reset is held.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (state_q == S_IDLE && reset_L) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = last_q;
        w_grant1 = ~last_q;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    jmodo_d = jmodo_q;
    jd_d    = jd_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant0 || w_grant1) begin
          id_d    = w_grant1;
          last_d  = w_grant1;
          jmodo_d = w_grant1 ? req1_modo : req0_modo;
          jd_d    = w_grant1 ? req1_D    : req0_D;
          rem_d   = w_grant1 ? req1_len  : req0_len;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wrap_d = 1'b0;
        if (rem_q == '0 || jmodo_q == MODO_LOAD) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rem_d  = rem_q - LW'(1);
        wrap_d = wrap_q | RCO[3];
        if (rem_q == LW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      jmodo_q     <= 2'b00;
      jd_q        <= '0;
      rem_q       <= '0;
      wrap_q      <= 1'b0;
      hold_id_q   <= 1'b0;
      hold_wrap_q <= 1'b0;
      hold_Q_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      jmodo_q <= jmodo_d;
      jd_q    <= jd_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      if (state_q == S_DONE) begin
        hold_id_q   <= id_q;
        hold_wrap_q <= wrap_q;
        hold_Q_q    <= Q;
      end
    end
  end

  // Counter-side outputs depend on registered state only.
  always_comb begin
    enb  = 1'b0;
    modo = 2'b00;
    D    = '0;
    case (state_q)
      S_LOAD: begin
        enb  = 1'b1;
        modo = MODO_LOAD;
        D    = jd_q;
      end
      S_RUN: begin
        enb  = 1'b1;
        modo = jmodo_q;
        D    = jd_q;
      end
      default: begin
        enb  = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // Q is already final during DONE (enb is low), so it is reported live and held after.
  assign done_Q    = done ? Q      : hold_Q_q;
  assign done_id   = done ? id_q   : hold_id_q;
  assign done_wrap = done ? wrap_q : hold_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_contador.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_contador
// Purpose  : Randomized and directed self-checking bench for controlador_contador.
// Revision : 1.0
// ============================================================================
module tb_controlador_contador;

  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          c_valid [2];
  logic [1:0]    c_modo  [2];
  logic [W-1:0]  c_D     [2];
  logic [LW-1:0] c_len   [2];
  logic          req0_ready, req1_ready;
  logic          enb, busy, done, done_id, done_wrap;
  logic [1:0]    modo;
  logic [W-1:0]  D, done_Q;
  logic [W-1:0]  cq = '0;
  logic [2:0]    rco_lo = '0;
  logic          rco3;

  controlador_contador #(.W(W), .LW(LW)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .req0_valid (c_valid[0]),
    .req0_ready (req0_ready),
    .req0_modo  (c_modo[0]),
    .req0_D     (c_D[0]),
    .req0_len   (c_len[0]),
    .req1_valid (c_valid[1]),
    .req1_ready (req1_ready),
    .req1_modo  (c_modo[1]),
    .req1_D     (c_D[1]),
    .req1_len   (c_len[1]),
    .enb        (enb),
    .modo       (modo),
    .D          (D),
    .Q          (cq),
    .RCO        ({rco3, rco_lo}),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .done_Q     (done_Q),
    .done_wrap  (done_wrap)
  );

  always #5 clk = ~clk;

  // Counter stand-in: RCO[3] flags that the current enabled step crosses the 16-bit range.
  always @(posedge clk) begin
    if (enb) begin
      case (modo)
        2'b00:   cq <= cq + 16'd1;
        2'b01:   cq <= cq - 16'd1;
        2'b10:   cq <= cq - 16'd3;
        default: cq <= D;
      endcase
    end
  end
  assign rco3 = enb && ((modo == 2'b00 && cq == 16'hFFFF) ||
                        (modo == 2'b01 && cq == 16'h0000) ||
                        (modo == 2'b10 && cq < 16'd3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: job position counted in cycles since accept.
  int           m_t = 0, m_total = 0, m_id = 0, m_len = 0, m_last = 1;
  logic [1:0]   m_modo = '0;
  logic [W-1:0] m_D = '0;
  logic [W-1:0] ld_Q = '0;
  int           ld_id = 0, ld_wrap = 0;
  bit           rand_mode = 0, auto_refill = 0;
  int           cyc = 0;
  int           acc_cyc [2];
  int           grants[$], rq[$], rid[$], rw[$], rlat[$];

  function automatic void expect_job(input logic [1:0] md, input logic [W-1:0] d, input int len,
                                     output logic [W-1:0] q, output int w);
    int dd;
    dd = int'(d);
    q  = d;
    w  = 0;
    if (md != 2'b11 && len != 0) begin
      case (md)
        2'b00:   begin q = 16'(dd + len);     w = (dd + len > 65535) ? 1 : 0; end
        2'b01:   begin q = 16'(dd - len);     w = (dd < len) ? 1 : 0;         end
        default: begin q = 16'(dd - 3 * len); w = (dd < 3 * len) ? 1 : 0;     end
      endcase
    end
  endfunction

  task automatic new_job(input int i);
    c_valid[i] = 1'b1;
    c_modo[i]  = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       c_D[i] = 16'hFFFF - 16'($urandom_range(0, 8));
      1:       c_D[i] = 16'($urandom_range(0, 8));
      default: c_D[i] = 16'($urandom);
    endcase
    c_len[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
  endtask

  task automatic set_job(input int i, input logic [1:0] md, input logic [W-1:0] d, input logic [LW-1:0] len);
    c_valid[i] = 1'b1;
    c_modo[i]  = md;
    c_D[i]     = d;
    c_len[i]   = len;
  endtask

  task automatic step();
    int           win;
    logic [W-1:0] eq;
    int           ew;
    @(negedge clk);
    win = -1;
    if (reset_L && m_t == 0) begin
      if (c_valid[0] && c_valid[1]) win = 1 - m_last;
      else if (c_valid[0])          win = 0;
      else if (c_valid[1])          win = 1;
    end
    check_val("ready0", req0_ready, (win == 0) ? 1 : 0);
    check_val("ready1", req1_ready, (win == 1) ? 1 : 0);
    check_val("busy", busy, (m_t != 0) ? 1 : 0);
    if (m_t == 0) begin
      check_val("idle_enb", enb, 0);
      check_val("idle_modo", modo, 0);
      check_val("idle_D", D, 0);
    end else if (m_t == 1) begin
      check_val("load_enb", enb, 1);
      check_val("load_modo", modo, 3);
      check_val("load_D", D, m_D);
    end else if (m_t < m_total) begin
      check_val("run_enb", enb, 1);
      check_val("run_modo", modo, m_modo);
      check_val("run_D", D, m_D);
    end else begin
      check_val("done_enb", enb, 0);
    end
    if (m_t != 0 && m_t == m_total) begin
      expect_job(m_modo, m_D, m_len, eq, ew);
      check_val("done", done, 1);
      check_val("done_Q", done_Q, eq);
      check_val("done_id", done_id, m_id);
      check_val("done_wrap", done_wrap, ew);
      ld_Q = eq; ld_id = m_id; ld_wrap = ew;
    end else begin
      check_val("no_done", done, 0);
      check_val("hold_Q", done_Q, ld_Q);
      check_val("hold_id", done_id, ld_id);
      check_val("hold_wrap", done_wrap, ld_wrap);
    end
    if (req0_ready) begin grants.push_back(0); acc_cyc[0] = cyc; end
    if (req1_ready) begin grants.push_back(1); acc_cyc[1] = cyc; end
    if (done === 1'b1) begin
      rq.push_back(int'(done_Q));
      rid.push_back(int'(done_id));
      rw.push_back(int'(done_wrap));
      rlat.push_back(cyc - acc_cyc[int'(done_id)]);
    end
    if (win >= 0) begin
      m_id    = win;
      m_modo  = c_modo[win];
      m_D     = c_D[win];
      m_len   = int'(c_len[win]);
      m_total = (m_len == 0 || m_modo == 2'b11) ? 2 : m_len + 2;
      m_last  = win;
      m_t     = 1;
    end else if (m_t != 0) begin
      m_t = (m_t == m_total) ? 0 : m_t + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    rco_lo = 3'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (win == i) begin
        if (auto_refill || (rand_mode && $urandom_range(0, 1) == 0)) new_job(i);
        else c_valid[i] = 1'b0;
      end else if (!c_valid[i] && rand_mode) begin
        if ($urandom_range(0, 5) == 0) begin
          new_job(i);
        end else begin
          c_modo[i] = 2'($urandom);
          c_D[i]    = 16'($urandom);
          c_len[i]  = 8'($urandom);
        end
      end
    end
  endtask

  task automatic run_dones(input int n, input int maxc);
    int start, k;
    start = rq.size();
    k = 0;
    while (rq.size() - start < n && k < maxc) begin
      step();
      k++;
    end
    check_val("dones_in_budget", (rq.size() - start >= n) ? 1 : 0, 1);
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    #1;
    check_val("rst_enb", enb, 0);
    check_val("rst_modo", modo, 0);
    check_val("rst_D", D, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_done_Q", done_Q, 0);
    check_val("rst_done_id", done_id, 0);
    check_val("rst_done_wrap", done_wrap, 0);
    check_val("rst_ready", {req1_ready, req0_ready}, 0);
    m_t = 0; m_last = 1; ld_Q = '0; ld_id = 0; ld_wrap = 0;
  endtask

  initial begin
    int g0, nd;
    reset_L = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c_valid[i] = 1'b0; c_modo[i] = '0; c_D[i] = '0; c_len[i] = '0; acc_cyc[i] = 0;
    end
    set_job(0, 2'b00, 16'h00FF, 8'd5);
    set_job(1, 2'b00, 16'hFFFE, 8'd3);
    apply_reset();
    repeat (3) step();
    reset_L = 1'b1;
    run_dones(2, 100);
    check_val("first_grant", grants[0], 0);
    check_val("second_grant", grants[1], 1);
    check_val("up_Q", rq[0], 16'h0104);
    check_val("up_id", rid[0], 0);
    check_val("up_wrap", rw[0], 0);
    check_val("up_lat", rlat[0], 7);
    check_val("wrap_Q", rq[1], 16'h0001);
    check_val("wrap_id", rid[1], 1);
    check_val("wrap_wrap", rw[1], 1);
    check_val("wrap_lat", rlat[1], 5);

    set_job(1, 2'b10, 16'h0004, 8'd2);
    run_dones(1, 50);
    check_val("dn3_Q", rq[$], 16'hFFFE);
    check_val("dn3_wrap", rw[$], 1);
    check_val("dn3_lat", rlat[$], 4);

    set_job(0, 2'b11, 16'h1234, 8'd9);
    run_dones(1, 50);
    check_val("ld11_Q", rq[$], 16'h1234);
    check_val("ld11_lat", rlat[$], 2);
    set_job(1, 2'b01, 16'h1234, 8'd0);
    run_dones(1, 50);
    check_val("len0_Q", rq[$], 16'h1234);
    check_val("len0_lat", rlat[$], 2);
    check_val("len0_wrap", rw[$], 0);

    apply_reset();
    repeat (2) step();
    new_job(0);
    new_job(1);
    auto_refill = 1;
    reset_L = 1'b1;
    g0 = grants.size();
    run_dones(4, 2000);
    for (int i = 0; i < 4; i++) check_val("rr_grant", grants[g0 + i], i % 2);
    auto_refill = 0;
    c_valid[0] = 1'b0;
    c_valid[1] = 1'b0;
    for (int k = 0; k < 400 && m_t != 0; k++) step();

    set_job(0, 2'b00, 16'h0100, 8'd10);
    g0 = grants.size();
    for (int k = 0; k < 20 && grants.size() == g0; k++) step();
    check_val("midrst_accept", grants.size() - g0, 1);
    repeat (3) step();
    #2;
    nd = rq.size();
    apply_reset();
    repeat (2) step();
    reset_L = 1'b1;
    set_job(1, 2'b00, 16'h0010, 8'd1);
    run_dones(1, 50);
    check_val("midrst_ndone", rq.size() - nd, 1);
    check_val("midrst_id", rid[$], 1);
    check_val("midrst_Q", rq[$], 16'h0011);

    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
